// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte-stream requesters.
// Packets are never interleaved. Optional HOLD timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int IDLE_TIMEOUT = 1024
) (
    input  logic                   i_CLK,
    input  logic                   i_RESET,
    input  logic [NUM_REQ-1:0]     i_req_VALID,
    input  logic [NUM_REQ*8-1:0]   i_req_DATA,
    input  logic [NUM_REQ-1:0]     i_req_LAST,
    output logic [NUM_REQ-1:0]     o_req_READY,
    output logic [NUM_REQ-1:0]     o_GRANT,
    output logic                   o_ARB_BUSY,
    output logic                   o_tx_DATA_READY,
    output logic [7:0]             o_tx_DATA,
    input  logic                   i_tx_BUSY,
    input  logic                   i_tx_DONE
);

    localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    logic [1:0]         r_state;
    logic [NUM_REQ-1:0] r_grant;
    logic [IDXW-1:0]    r_owner;
    logic [IDXW-1:0]    r_last_owner;
    logic [7:0]         r_data;
    logic               r_last;
`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0]        r_tmo;
`endif

    logic [IDXW-1:0]    w_win;
    logic               w_win_vld;
    logic [IDXW-1:0]    w_sel;
    logic [NUM_REQ-1:0] w_ready;
    logic               w_take;
    logic [7:0]         w_byte;
    logic               w_byte_last;
    logic [NUM_REQ-1:0] w_sel_onehot;

    // Highest priority goes to the requester right after the previous owner.
    function automatic logic [IDXW-1:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                                input logic [IDXW-1:0]    last);
        int idx;
        logic [IDXW-1:0] pick;
        pick = last;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last) + i) % NUM_REQ;
            if (vld[idx]) pick = IDXW'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        w_win     = rr_pick(i_req_VALID, r_last_owner);
        w_win_vld = |i_req_VALID;
    end

    always_comb begin
        w_ready = '0;
        w_sel   = (r_state == S_HOLD) ? r_owner : w_win;
        if (!i_RESET) begin
            if (r_state == S_IDLE && w_win_vld && !i_tx_BUSY)
                w_ready[w_win] = 1'b1;
            else if (r_state == S_HOLD && i_req_VALID[r_owner])
                w_ready[r_owner] = 1'b1;
        end
    end

    always_comb begin
        w_take       = |w_ready;
        w_byte       = i_req_DATA[w_sel*8 +: 8];
        w_byte_last  = i_req_LAST[w_sel];
        w_sel_onehot = NUM_REQ'(1) << w_sel;
    end

    always_ff @(posedge i_CLK) begin
        if (i_RESET) begin
            r_state      <= S_IDLE;
            r_grant      <= '0;
            r_owner      <= '0;
            r_last_owner <= IDXW'(NUM_REQ - 1);
            r_data       <= 8'h00;
            r_last       <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            r_tmo        <= 16'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_data  <= w_byte;
                        r_last  <= w_byte_last;
                        r_owner <= w_sel;
                        r_grant <= w_sel_onehot;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: r_state <= S_WAIT;
                S_WAIT: begin
                    if (i_tx_DONE) begin
                        if (r_last) begin
                            r_grant      <= '0;
                            r_last_owner <= r_owner;
                            r_state      <= S_IDLE;
                        end else begin
                            r_state <= S_HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                            r_tmo   <= 16'd0;
`endif
                        end
                    end
                end
                S_HOLD: begin
                    if (w_take) begin
                        r_data  <= w_byte;
                        r_last  <= w_byte_last;
                        r_state <= S_SEND;
`ifdef UART_ARB_TIMEOUT_EN
                    end else if (r_tmo == 16'(IDLE_TIMEOUT - 1)) begin
                        // Stalled owner gives up the transmitter; a late byte starts a new packet.
                        r_grant      <= '0;
                        r_last_owner <= r_owner;
                        r_state      <= S_IDLE;
                    end else begin
                        r_tmo <= r_tmo + 16'd1;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_READY     = w_ready;
    assign o_GRANT         = r_grant;
    assign o_ARB_BUSY      = (r_state != S_IDLE);
    assign o_tx_DATA_READY = (r_state == S_SEND);
    assign o_tx_DATA       = r_data;

endmodule
